// File: rtl/game_counter_bcd.sv
// game_counter_bcd: multi-digit BCD up/down score counter
// with hold-to-repeat buttons, preset load and wrap/saturate limits.
module game_counter_bcd #(
  parameter int NUM_DIGITS   = 2,
  parameter int MAX_VALUE    = 99,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc_btn,
  input  logic                    dec_btn,
  input  logic                    sat_mode,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    at_min,
  output logic                    at_max,
  output logic                    wrap_pulse,
  output logic                    sat_pulse
);

  localparam int W = 4 * NUM_DIGITS;

  function automatic logic [W-1:0] f_to_bcd(input int n);
    logic [W-1:0] b;
    int           r;
    b = '0;
    r = n;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  localparam logic [W-1:0] MAX_BCD = f_to_bcd(MAX_VALUE);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam bit RPT_EN = (REPEAT_DELAY != 0);
  localparam logic [TW-1:0] DLY_M1 =
    TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] RATE_M1 = TW'(REPEAT_RATE - 1);

  logic [W-1:0]  r_value;
  logic          r_inc_q;
  logic          r_dec_q;
  logic [TW-1:0] r_tmr;
  logic          r_wrap;
  logic          r_sat;

  logic          w_inc_ex;
  logic          w_dec_ex;
  logic          w_held;
  logic          w_first;
  logic          w_rep;
  logic          w_up;
  logic          w_dn;
  logic [W-1:0]  w_inc_val;
  logic [W-1:0]  w_dec_val;
  logic          w_ld_bad;
  logic [W-1:0]  w_ld_val;
  logic [W-1:0]  w_nxt;
  logic          w_wrap;
  logic          w_sat;

  // A repeat fires once the countdown from the press (or load) expires.
  assign w_inc_ex = inc_btn & ~dec_btn;
  assign w_dec_ex = dec_btn & ~inc_btn;
  assign w_held   = w_inc_ex | w_dec_ex;
  assign w_first  = (w_inc_ex & ~r_inc_q) | (w_dec_ex & ~r_dec_q);
  assign w_rep    = RPT_EN && (r_tmr == '0);
  assign w_up     = w_inc_ex & (~r_inc_q | w_rep);
  assign w_dn     = w_dec_ex & (~r_dec_q | w_rep);

  // Ripple carry / borrow across the BCD digits.
  always_comb begin
    logic cy;
    logic bw;
    w_inc_val = r_value;
    w_dec_val = r_value;
    cy = 1'b1;
    bw = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (r_value[4*i +: 4] == 4'd9) begin
          w_inc_val[4*i +: 4] = 4'd0;
        end else begin
          w_inc_val[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (r_value[4*i +: 4] == 4'd0) begin
          w_dec_val[4*i +: 4] = 4'd9;
        end else begin
          w_dec_val[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  // Preset is clamped to MAX on a bad digit or an out-of-range value;
  // with valid digits BCD order matches binary order.
  always_comb begin
    w_ld_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) w_ld_bad = 1'b1;
    end
    w_ld_val = (w_ld_bad || (load_value > MAX_BCD)) ?
               MAX_BCD : load_value;
  end

  // Next count and status: load beats steps, limits wrap or saturate.
  always_comb begin
    w_nxt  = r_value;
    w_wrap = 1'b0;
    w_sat  = 1'b0;
    if (load) begin
      w_nxt = w_ld_val;
    end else if (w_up) begin
      if (r_value == MAX_BCD) begin
        if (sat_mode) begin
          w_sat = 1'b1;
        end else begin
          w_nxt  = '0;
          w_wrap = 1'b1;
        end
      end else begin
        w_nxt = w_inc_val;
      end
    end else if (w_dn) begin
      if (r_value == '0) begin
        if (sat_mode) begin
          w_sat = 1'b1;
        end else begin
          w_nxt  = MAX_BCD;
          w_wrap = 1'b1;
        end
      end else begin
        w_nxt = w_dec_val;
      end
    end
  end

  // Count, status pulses and button history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
      r_inc_q <= 1'b0;
      r_dec_q <= 1'b0;
    end else begin
      r_value <= w_nxt;
      r_wrap  <= w_wrap;
      r_sat   <= w_sat;
      r_inc_q <= w_inc_ex;
      r_dec_q <= w_dec_ex;
    end
  end

  // Repeat countdown: armed by a fresh press or a load, reloaded per repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr <= '0;
    end else if (!w_held) begin
      r_tmr <= '0;
    end else if (load || w_first) begin
      r_tmr <= DLY_M1;
    end else if (w_rep) begin
      r_tmr <= RATE_M1;
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - TW'(1);
    end
  end

  assign value      = r_value;
  assign at_min     = (r_value == '0);
  assign at_max     = (r_value == MAX_BCD);
  assign wrap_pulse = r_wrap;
  assign sat_pulse  = r_sat;

endmodule

// File: tb/tb_game_counter_bcd.sv
// tb_game_counter_bcd: directed + random stimulus against an
// integer reference model of the score counter.
module tb_game_counter_bcd;

  localparam int ND = 2;
  localparam int MV = 75;
  localparam int RD = 10;
  localparam int RR = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       sat = 1'b0;
  logic       ld  = 1'b0;
  logic [7:0] lv  = 8'h00;
  logic [7:0] value;
  logic       at_min;
  logic       at_max;
  logic       wrap_pulse;
  logic       sat_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  int mv   = 0;
  int pexc = 0;
  int k    = 0;
  bit mw   = 0;
  bit ms   = 0;

  game_counter_bcd #(
    .NUM_DIGITS  (ND),
    .MAX_VALUE   (MV),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .inc_btn   (inc),
    .dec_btn   (dec),
    .sat_mode  (sat),
    .load      (ld),
    .load_value(lv),
    .value     (value),
    .at_min    (at_min),
    .at_max    (at_max),
    .wrap_pulse(wrap_pulse),
    .sat_pulse (sat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic int clampv(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    int         n;
    hi = v[7:4];
    lo = v[3:0];
    if (hi > 9 || lo > 9) return MV;
    n = int'(hi) * 10 + int'(lo);
    return (n > MV) ? MV : n;
  endfunction

  // k counts cycles since the press (or the load) of the held button.
  task automatic model_step();
    int exc;
    bit st;
    exc = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
    st  = 0;
    if (exc == 0) begin
      k = 0;
    end else if (exc != pexc) begin
      k  = 0;
      st = 1;
    end else begin
      k++;
      if (RD > 0 && k >= RD && ((k - RD) % RR) == 0) st = 1;
    end
    mw = 0;
    ms = 0;
    if (ld) begin
      if (exc != 0) k = 0;
      mv = clampv(lv);
    end else if (st && exc > 0) begin
      if (mv == MV) begin
        if (sat) ms = 1;
        else begin mv = 0; mw = 1; end
      end else mv++;
    end else if (st && exc < 0) begin
      if (mv == 0) begin
        if (sat) ms = 1;
        else begin mv = MV; mw = 1; end
      end else mv--;
    end
    pexc = exc;
  endtask

  task automatic model_reset();
    mv = 0; pexc = 0; k = 0; mw = 0; ms = 0;
  endtask

  task automatic cmp_all();
    chk("value", value, bcd(mv));
    chk("wrap", wrap_pulse, mw);
    chk("sat", sat_pulse, ms);
    chk("at_min", at_min, mv == 0);
    chk("at_max", at_max, mv == MV);
    chk("excl", wrap_pulse & sat_pulse, 0);
  endtask

  task automatic step_cyc();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    cmp_all();
  endtask

  task automatic drive(input bit i, input bit d, input int n);
    inc = i;
    dec = d;
    repeat (n) step_cyc();
  endtask

  task automatic load_v(input logic [7:0] v, input bit i, input bit d);
    ld  = 1'b1;
    lv  = v;
    inc = i;
    dec = d;
    step_cyc();
    ld  = 1'b0;
  endtask

  initial begin
    #12;
    model_reset();
    cmp_all();
    rst = 1'b0;

    // wrap at both limits
    load_v(8'h74, 0, 0);
    drive(1, 0, 1);
    drive(0, 0, 1);
    drive(1, 0, 1);
    chk("wrap_up_val", value, 8'h00);
    chk("wrap_up_pl", wrap_pulse, 1);
    drive(0, 0, 1);
    chk("wrap_one_cyc", wrap_pulse, 0);
    drive(0, 1, 1);
    chk("wrap_dn_val", value, 8'h75);
    chk("wrap_dn_pl", wrap_pulse, 1);
    drive(0, 0, 1);

    // saturation
    sat = 1'b1;
    load_v(8'h75, 0, 0);
    drive(1, 0, 1);
    chk("sat_up_val", value, 8'h75);
    chk("sat_up_pl", sat_pulse, 1);
    drive(0, 0, 1);
    load_v(8'h00, 0, 0);
    drive(0, 1, 1);
    chk("sat_dn_val", value, 8'h00);
    chk("sat_dn_pl", sat_pulse, 1);
    drive(0, 0, 1);
    sat = 1'b0;

    // carry / borrow across digits
    load_v(8'h19, 0, 0);
    drive(1, 0, 1);
    chk("carry", value, 8'h20);
    drive(0, 0, 1);
    drive(0, 1, 1);
    chk("borrow", value, 8'h19);
    drive(0, 0, 1);
    load_v(8'h10, 0, 0);
    drive(0, 1, 1);
    chk("borrow10", value, 8'h09);
    drive(0, 0, 1);

    // auto-repeat, then both buttons, then release of dec
    load_v(8'h00, 0, 0);
    drive(1, 0, 25);
    chk("rep_final", value, 8'h05);
    drive(1, 1, 8);
    chk("both_hold", value, 8'h05);
    drive(1, 0, 1);
    chk("repress", value, 8'h06);
    drive(0, 0, 1);

    // load priority and clamping
    load_v(8'h37, 1, 0);
    chk("ld_prio", value, 8'h37);
    drive(1, 0, 3);
    chk("ld_nofire", value, 8'h37);
    drive(0, 0, 1);
    load_v(8'h5A, 0, 0);
    chk("ld_bad_dig", value, 8'h75);
    load_v(8'h80, 0, 0);
    chk("ld_over", value, 8'h75);
    load_v(8'h76, 0, 0);
    chk("ld_max1", value, 8'h75);

    // asynchronous reset while inc is held
    load_v(8'h57, 1, 0);
    drive(1, 0, 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst", value, 8'h00);
    cmp_all();
    #2 rst = 1'b0;
    step_cyc();
    chk("rst_fresh", value, 8'h01);
    drive(1, 0, 12);
    chk("rst_rep", value, 8'h02);
    drive(0, 0, 1);

    // random segments
    for (int s = 0; s < 60; s++) begin
      int pat;
      int len;
      pat = $urandom_range(0, 3);
      len = $urandom_range(1, 30);
      sat = 1'($urandom_range(0, 1));
      inc = pat[0];
      dec = pat[1];
      for (int c = 0; c < len; c++) begin
        ld = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 1) == 1)
          lv = 8'($urandom_range(0, 255));
        else
          lv = bcd($urandom_range(0, 99));
        step_cyc();
      end
      ld = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_counter_bcd.md
Name: game_counter_bcd

Overview:
Multi-digit BCD up/down counter for game score and level displays. It is the parametrised successor of the single-digit 0–9 counter and adds:
- configurable digit count and upper limit
- run-time choice between wrap-around and saturation
- synchronous preset load
- hold-to-repeat stepping
- wrap and saturation status pulses

Its outputs feed the 7-segment digit mux directly. Its button inputs arrive already debounced and synchronised to clk.

Parameters:
NUM_DIGITS, 2, number of BCD digits; legal range 1–4.
MAX_VALUE, 99, decimal upper limit of the count; must be ≤ 10^NUM_DIGITS − 1. The lower limit is always 0.
REPEAT_DELAY, 5000000, cycles a button must be held before auto-repeat starts; 0 disables auto-repeat.
REPEAT_RATE, 1000000, cycles between auto-repeat steps; must be ≥ 1.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high global reset.
inc_btn  in  1  increment button, level; 1 = pressed.
dec_btn  in  1  decrement button, level; 1 = pressed.
sat_mode  in  1  0 = wrap at the limits; 1 = saturate at the limits.
load  in  1  single-cycle strobe that presets the count.
load_value  in  4*NUM_DIGITS  BCD preset value; digit 0 is in bits [3:0].
value  out  4*NUM_DIGITS  current count in BCD, registered.
at_min  out  1  high while value == 0; combinational from value.
at_max  out  1  high while value == MAX_VALUE; combinational from value.
wrap_pulse  out  1  high for one cycle after a step that wrapped.
sat_pulse  out  1  high for one cycle after a step blocked by saturation.

Behaviour:
- Reset (asynchronous, any time, including mid-repeat):
  - value = 0, wrap_pulse = 0, sat_pulse = 0.
  - Button-history registers and the repeat timer are cleared.
  - A button held through reset release is treated as a fresh press on the first clock after release.
- Step generation (a step is an internal single-cycle event):
  - Exclusive inc: inc_btn=1 and dec_btn=0.
  - An up-step fires in the cycle the exclusive-inc condition first becomes true (edge relative to the previous cycle).
  - While it stays true, further up-steps fire at REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, REPEAT_DELAY+2*REPEAT_RATE, … cycles after that first cycle.
  - Down-steps are generated symmetrically from exclusive dec.
  - Both buttons high, or neither high: no step, and the repeat timer is cleared.
  - Releasing the second button while one stays held counts as a new press of the remaining button.
- Latency: a step in cycle N updates value at the rising edge ending cycle N, so the new value is visible in cycle N+1. wrap_pulse and sat_pulse are valid in that same N+1 cycle.
- Arithmetic:
  - Per-digit BCD with ripple carry/borrow across digits.
  - Digits never hold a value above 9.
  - Up from MAX_VALUE: goes to 0 with wrap_pulse=1 if sat_mode=0; stays at MAX_VALUE with sat_pulse=1 if sat_mode=1.
  - Down from 0: goes to MAX_VALUE with wrap_pulse=1 if sat_mode=0; stays at 0 with sat_pulse=1 if sat_mode=1.
  - MAX_VALUE is held internally as a BCD constant derived from the integer parameter.
- Load:
  - load has priority over any step in the same cycle; that step is discarded.
  - Button history is still updated, so a held button does not re-fire because of the load.
  - load restarts the repeat timer of a held button.
  - If any digit of load_value is > 9, or load_value > MAX_VALUE, value takes MAX_VALUE.
  - A load never asserts wrap_pulse or sat_pulse.
- sat_mode may change on any cycle. It takes effect on the next step and does not alter the current value.
- Status pulses: wrap_pulse and sat_pulse are never both high, and each lasts exactly one cycle per causing step.

Test Plan:
- Wrap, defaults, sat_mode=0: load 98; press inc (hold 1 cycle) twice -> value 99, then 00 with wrap_pulse=1 for exactly one cycle. Press dec at 00 -> 99, wrap_pulse=1.
- Saturation, sat_mode=1, MAX_VALUE=42: load 42; inc -> stays 42, sat_pulse=1, at_max=1. Load 0; dec -> stays 00, sat_pulse=1, at_min=1.
- Carry chain, NUM_DIGITS=3, MAX_VALUE=999: load 199; inc -> 200. Dec -> 199. Load 100; dec -> 099.
- Auto-repeat, REPEAT_DELAY=10, REPEAT_RATE=4: hold inc for 25 cycles from value 0 -> steps at cycles 0, 10, 14, 18, 22, final value 5. Assert dec during the hold -> no steps while both are high.
- Load priority and clamping: inc rising edge coincides with load=1, load_value=0x37 -> value 37, no step. Load_value 0x5A (invalid digit) -> value 99. Load_value 0x60 with MAX_VALUE=50 -> value 50.
- Reset mid-operation: reset asserted asynchronously between clock edges while inc is held at value 57 -> value 00 immediately. Release reset with inc still high -> one step to 01 on the first clock, then repeat timing restarts from that cycle.
